// File: rtl/pixel_pack_write_pkg.sv
// Shared widths, write-FSM state encoding and the optional test-pattern
// helper for the pixel pack/write path (pattern enabled by WRITE_PATTERN_EN).
package pixel_pack_write_pkg;

  localparam int LOG_MEM    = 36;
  localparam int LOG_HCOUNT = 10;
  localparam int LOG_VCOUNT = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } wr_state_e;

`ifdef WRITE_PATTERN_EN
  // YCrCb layout: Y in [17:10], Cr in [9:5], Cb in [4:0].
  function automatic logic [17:0] pattern_pixel(input logic [LOG_HCOUNT-1:0] h,
                                                input logic [LOG_VCOUNT-1:0] v);
    return {h[7:0], v[4:0], 5'd0};
  endfunction
`endif

endpackage

// File: rtl/pixel_word_fifo.sv
// Synchronous FIFO with extra-bit pointers; a push while full is accepted
// only when a pop happens in the same cycle.
module pixel_word_fifo #(
  parameter int WIDTH    = 56,
  parameter int FIFO_LOG = 3
) (
  input  logic             clock,
  input  logic             reset_b,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int DEPTH = 1 << FIFO_LOG;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [FIFO_LOG:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG:0] rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[FIFO_LOG] != rd_ptr_q[FIFO_LOG]) &&
                   (wr_ptr_q[FIFO_LOG-1:0] == rd_ptr_q[FIFO_LOG-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign head_o  = mem_q[rd_ptr_q[FIFO_LOG-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{FIFO_LOG{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{FIFO_LOG{1'b0}}, do_pop};
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q[FIFO_LOG-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/pixel_pack_write.sv
// Packs even/odd YCrCb pixel pairs into 36-bit words, queues them and issues
// them with a flag/done handshake. WRITE_PATTERN_EN swaps pixels for a pattern.
module pixel_pack_write
  import pixel_pack_write_pkg::*;
#(
  parameter int FIFO_LOG = 3,
  parameter int PIX_W    = 18
) (
  input  logic                  clock,
  input  logic                  reset_b,
  input  logic                  frame_flag,
  input  logic                  in_valid,
  input  logic [PIX_W-1:0]      in_pixel,
  input  logic [LOG_HCOUNT-1:0] in_hcount,
  input  logic [LOG_VCOUNT-1:0] in_vcount,
  output logic                  write_flag,
  output logic [2*PIX_W-1:0]    write_pixel,
  output logic [LOG_HCOUNT-1:0] write_hcount,
  output logic [LOG_VCOUNT-1:0] write_vcount,
  input  logic                  done_write,
  output logic                  busy,
  output logic                  overflow
);

  localparam int WORD_W  = 2 * PIX_W;
  localparam int ENTRY_W = LOG_VCOUNT + LOG_HCOUNT + WORD_W;

  // Valid/ready: the FSM raises write_flag for one cycle in REQ; the word,
  // hcount and vcount stay stable through WAIT until done_write retires it.

  logic                  hold_valid_q, hold_valid_d;
  logic [PIX_W-1:0]      hold_pixel_q, hold_pixel_d;
  logic [LOG_HCOUNT-1:0] hold_h_q, hold_h_d;
  logic [LOG_VCOUNT-1:0] hold_v_q, hold_v_d;
  logic                  ovf_q, ovf_d;
  wr_state_e             state_q, state_d;
  logic [WORD_W-1:0]     wr_word_q, wr_word_d;
  logic [LOG_HCOUNT-1:0] wr_h_q, wr_h_d;
  logic [LOG_VCOUNT-1:0] wr_v_q, wr_v_d;

  logic                  hold_live;
  logic                  push, pop;
  logic                  fifo_full, fifo_empty;
  logic [WORD_W-1:0]     push_word;
  logic [ENTRY_W-1:0]    push_entry, head_entry;

`ifdef WRITE_PATTERN_EN
  logic unused_pixel;
  assign unused_pixel = ^hold_pixel_q;
  assign push_word = {pattern_pixel(in_hcount, in_vcount),
                      pattern_pixel(hold_h_q, hold_v_q)};
`else
  assign push_word = {in_pixel, hold_pixel_q};
`endif

  assign push_entry = {hold_v_q, hold_h_q, push_word};

  // frame_flag takes effect before the pixel presented in the same cycle.
  assign hold_live = hold_valid_q && !frame_flag;

  always_comb begin
    hold_valid_d = hold_live;
    hold_pixel_d = hold_pixel_q;
    hold_h_d     = hold_h_q;
    hold_v_d     = hold_v_q;
    ovf_d        = ovf_q && !frame_flag;
    push         = 1'b0;
    if (in_valid) begin
      if (!in_hcount[0]) begin
        hold_valid_d = 1'b1;
        hold_pixel_d = in_pixel;
        hold_h_d     = in_hcount;
        hold_v_d     = in_vcount;
      end else if (hold_live && (in_hcount == hold_h_q + LOG_HCOUNT'(1)) &&
                   (in_vcount == hold_v_q)) begin
        push         = 1'b1;
        hold_valid_d = 1'b0;
      end
    end
    if (push && fifo_full && !pop) ovf_d = 1'b1;
  end

  pixel_word_fifo #(
    .WIDTH   (ENTRY_W),
    .FIFO_LOG(FIFO_LOG)
  ) u_fifo (
    .clock      (clock),
    .reset_b    (reset_b),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .head_o     (head_entry)
  );

  always_comb begin
    state_d   = state_q;
    wr_word_d = wr_word_q;
    wr_h_d    = wr_h_q;
    wr_v_d    = wr_v_q;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          {wr_v_d, wr_h_d, wr_word_d} = head_entry;
          state_d = REQ;
        end
      end
      REQ: state_d = WAIT;
      WAIT: begin
        if (done_write) begin
          pop     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      hold_valid_q <= 1'b0;
      hold_pixel_q <= '0;
      hold_h_q     <= '0;
      hold_v_q     <= '0;
      ovf_q        <= 1'b0;
      state_q      <= IDLE;
      wr_word_q    <= '0;
      wr_h_q       <= '0;
      wr_v_q       <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_pixel_q <= hold_pixel_d;
      hold_h_q     <= hold_h_d;
      hold_v_q     <= hold_v_d;
      ovf_q        <= ovf_d;
      state_q      <= state_d;
      wr_word_q    <= wr_word_d;
      wr_h_q       <= wr_h_d;
      wr_v_q       <= wr_v_d;
    end
  end

  // All outputs are decoded from flops only.
  assign write_flag   = (state_q == REQ);
  assign write_pixel  = wr_word_q;
  assign write_hcount = wr_h_q;
  assign write_vcount = wr_v_q;
  assign busy         = !fifo_empty || (state_q != IDLE);
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_pixel_pack_write.sv
// Randomized and directed bench for pixel_pack_write against a queue-based
// reference model; set WRITE_PATTERN_EN to check the pattern build.
`timescale 1ns/1ps
module tb_pixel_pack_write;
  import pixel_pack_write_pkg::*;

  // clock / reset
  logic        clock = 1'b0;
  logic        reset_b = 1'b0;
  logic        frame_flag = 1'b0;
  logic        in_valid = 1'b0;
  logic [17:0] in_pixel = '0;
  logic [9:0]  in_hcount = '0;
  logic [9:0]  in_vcount = '0;
  logic        done_write = 1'b0;
  logic        write_flag;
  logic [35:0] write_pixel;
  logic [9:0]  write_hcount;
  logic [9:0]  write_vcount;
  logic        busy;
  logic        overflow;

  always #5 clock = ~clock;

  pixel_pack_write #(.FIFO_LOG(3), .PIX_W(18)) dut (
    .clock       (clock),
    .reset_b     (reset_b),
    .frame_flag  (frame_flag),
    .in_valid    (in_valid),
    .in_pixel    (in_pixel),
    .in_hcount   (in_hcount),
    .in_vcount   (in_vcount),
    .write_flag  (write_flag),
    .write_pixel (write_pixel),
    .write_hcount(write_hcount),
    .write_vcount(write_vcount),
    .done_write  (done_write),
    .busy        (busy),
    .overflow    (overflow)
  );

  // scoreboard state
  int n_checks = 0;
  int n_bad    = 0;

  logic [55:0] exp_q[$];
  bit          hold_ok = 0;
  logic [9:0]  hold_h = '0, hold_v = '0;
  logic [17:0] hold_p = '0;
  bit          ovf_m = 0;
  bit          wait_m = 0;
  bit          auto_done = 0;
  int          cyc = 0;
  int          n_flags = 0;
  int          last_flag_cyc = -100;
  logic [35:0] last_flag_word = '0;
  logic [9:0]  last_flag_h = '0, last_flag_v = '0;
  int          flag_cyc_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [35:0] model_word(input logic [9:0] h_even, input logic [9:0] v,
                                             input logic [17:0] p_even, input logic [17:0] p_odd);
`ifdef WRITE_PATTERN_EN
    logic [9:0] h_odd;
    h_odd = h_even + 10'd1;
    return {h_odd[7:0], v[4:0], 5'd0, h_even[7:0], v[4:0], 5'd0};
`else
    return {p_odd, p_even};
`endif
  endfunction

  // driver: observe outputs at negedge, then drive inputs for the next posedge
  task automatic cyc_step(input bit ff, input bit vld, input logic [17:0] pix,
                          input logic [9:0] h, input logic [9:0] v, input bit dn);
    bit          pop;
    bit          dn_eff;
    logic [55:0] e;
    @(negedge clock);
    cyc++;
    check_eq("busy", busy, exp_q.size() != 0);
    check_eq("overflow", overflow, ovf_m);
    if (write_flag) begin
      n_flags++;
      last_flag_cyc  = cyc;
      last_flag_word = write_pixel;
      last_flag_h    = write_hcount;
      last_flag_v    = write_vcount;
      flag_cyc_q.push_back(cyc);
      check_eq("flag_one_cycle", wait_m, 0);
      if (exp_q.size() == 0) check_eq("flag_spurious", write_flag, 0);
      else begin
        e = exp_q[0];
        check_eq("wr_pixel", write_pixel, e[35:0]);
        check_eq("wr_hcount", write_hcount, e[45:36]);
        check_eq("wr_vcount", write_vcount, e[55:46]);
      end
    end else if (wait_m && exp_q.size() != 0) begin
      e = exp_q[0];
      check_eq("wr_stable", {write_vcount, write_hcount, write_pixel}, e);
    end
    dn_eff = auto_done ? wait_m : dn;
    pop = wait_m && dn_eff;
    if (pop) begin
      wait_m = 0;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
    if (write_flag) wait_m = 1;

    frame_flag = ff;
    in_valid   = vld;
    in_pixel   = pix;
    in_hcount  = h;
    in_vcount  = v;
    done_write = dn_eff;

    if (ff) begin
      hold_ok = 0;
      ovf_m   = 0;
    end
    if (vld) begin
      if (!h[0]) begin
        hold_ok = 1;
        hold_h  = h;
        hold_v  = v;
        hold_p  = pix;
      end else if (hold_ok && (int'(h) == int'(hold_h) + 1) && (v == hold_v)) begin
        hold_ok = 0;
        if (exp_q.size() < 8) exp_q.push_back({hold_v, hold_h, model_word(hold_h, hold_v, hold_p, pix)});
        else ovf_m = 1;
      end
    end
  endtask

  task automatic idle(input int n, input bit dn);
    for (int i = 0; i < n; i++) cyc_step(0, 0, 18'd0, 10'd0, 10'd0, dn);
  endtask

  task automatic send_pair(input logic [9:0] x, input logic [9:0] y, input bit dn);
    cyc_step(0, 1, 18'($urandom), x, y, dn);
    cyc_step(0, 1, 18'($urandom), x + 10'd1, y, dn);
  endtask

  task automatic wait_flag(input int f0);
    int k = 0;
    while (n_flags == f0 && k < 20) begin
      cyc_step(0, 0, 18'd0, 10'd0, 10'd0, 0);
      k++;
    end
    if (n_flags == f0) check_eq("wait_flag_timeout", 0, 1);
  endtask

  task automatic drain();
    int k = 0;
    auto_done = 1;
    while ((exp_q.size() != 0 || busy) && k < 300) begin
      cyc_step(0, 0, 18'd0, 10'd0, 10'd0, 0);
      k++;
    end
    auto_done = 0;
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  logic [9:0] r_h, r_v, prev_h, prev_v;
  bit         r_vld, r_ff, r_dn;
  int         f0, t_push;

  initial begin
    #1;
    check_eq("rst_flag", write_flag, 0);
    check_eq("rst_pixel", write_pixel, 0);
    check_eq("rst_hcount", write_hcount, 0);
    check_eq("rst_vcount", write_vcount, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_overflow", overflow, 0);
    @(negedge clock);
    @(negedge clock);
    reset_b = 1'b1;

    // pair and write
    f0 = n_flags;
    cyc_step(0, 1, 18'h00001, 10'd10, 10'd5, 0);
    cyc_step(0, 1, 18'h00002, 10'd11, 10'd5, 0);
    t_push = cyc;
    wait_flag(f0);
    check_eq("t1_latency", last_flag_cyc - t_push, 2);
    check_eq("t1_hcount", last_flag_h, 10);
    check_eq("t1_vcount", last_flag_v, 5);
`ifndef WRITE_PATTERN_EN
    check_eq("t1_pixel", last_flag_word, 36'h000080001);
`endif
    idle(4, 0);
    idle(1, 1);
    idle(1, 0);
    check_eq("t1_busy_after", busy, 0);
    check_eq("t1_flag_count", n_flags - f0, 1);

    // orphans
    f0 = n_flags;
    cyc_step(0, 1, 18'($urandom), 10'd13, 10'd7, 0);
    cyc_step(0, 1, 18'($urandom), 10'd20, 10'd7, 0);
    cyc_step(0, 1, 18'($urandom), 10'd22, 10'd7, 0);
    cyc_step(0, 1, 18'($urandom), 10'd23, 10'd7, 0);
    drain();
    check_eq("orph_count", n_flags - f0, 1);
    check_eq("orph_hcount", last_flag_h, 22);

    // overflow then frame_flag clear and drain
    f0 = n_flags;
    for (int i = 0; i < 9; i++) send_pair(10'(100 + 2 * i), 10'd9, 0);
    idle(1, 0);
    check_eq("ovf_set", overflow, 1);
    cyc_step(1, 0, 18'd0, 10'd0, 10'd0, 0);
    idle(1, 0);
    check_eq("ovf_clear", overflow, 0);
    drain();
    check_eq("ovf_drain_words", n_flags - f0, 8);

    // back-to-back
    flag_cyc_q.delete();
    auto_done = 1;
    for (int i = 0; i < 4; i++) send_pair(10'(200 + 2 * i), 10'd20, 0);
    drain();
    check_eq("b2b_count", flag_cyc_q.size(), 4);
    for (int i = 1; i < flag_cyc_q.size(); i++)
      check_eq("b2b_gap", flag_cyc_q[i] - flag_cyc_q[i-1], 3);

`ifdef WRITE_PATTERN_EN
    f0 = n_flags;
    send_pair(10'd4, 10'd3, 0);
    wait_flag(f0);
    check_eq("pat_lo_y", last_flag_word[17:10], 8'h04);
    check_eq("pat_hi_y", last_flag_word[35:28], 8'h05);
    check_eq("pat_cr", last_flag_word[9:5], 5'd3);
    check_eq("pat_cb", last_flag_word[4:0], 5'd0);
    drain();
`endif

    // async reset during WAIT
    for (int i = 0; i < 9; i++) send_pair(10'(300 + 2 * i), 10'd30, 0);
    idle(2, 0);
    check_eq("rst_pre_busy", busy, 1);
    check_eq("rst_pre_ovf", overflow, 1);
    check_eq("rst_pre_wait", wait_m, 1);
    in_valid = 1'b0;
    frame_flag = 1'b0;
    done_write = 1'b0;
    #2 reset_b = 1'b0;
    #1;
    check_eq("arst_flag", write_flag, 0);
    check_eq("arst_busy", busy, 0);
    check_eq("arst_overflow", overflow, 0);
    exp_q.delete();
    hold_ok = 0;
    ovf_m = 0;
    wait_m = 0;
    @(negedge clock);
    reset_b = 1'b1;
    idle(3, 0);
    check_eq("arst_fifo_empty", busy, 0);

    // randomized traffic with varying memory responsiveness
    prev_h = 10'd0;
    prev_v = 10'd0;
    for (int seg = 0; seg < 6; seg++) begin
      for (int n = 0; n < 300; n++) begin
        if (!prev_h[0] && $urandom_range(0, 99) < 65) begin
          r_h = prev_h + 10'd1;
          r_v = ($urandom_range(0, 19) == 0) ? prev_v + 10'd1 : prev_v;
        end else begin
          r_h = 10'($urandom_range(0, 639));
          r_v = 10'($urandom_range(0, 479));
          if ($urandom_range(0, 1) == 1) r_h[0] = 1'b0;
        end
        r_vld = ($urandom_range(0, 99) < 75);
        r_ff  = ($urandom_range(0, 99) < 2);
        r_dn  = ($urandom_range(0, 99) < (seg * 18));
        if (r_vld) begin
          prev_h = r_h;
          prev_v = r_v;
        end
        cyc_step(r_ff, r_vld, 18'($urandom), r_h, r_v, r_dn);
      end
    end
    drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
